// File: rtl/sys1_load_sequencer_if.sv
// ioctl download bus from hps_io into the System 1 load sequencer.
// master drives the download stream, slave consumes it.
interface sys1_load_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_index,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_index,
    input ioctl_addr,
    input ioctl_dout
  );
endinterface

// File: rtl/sys1_load_sequencer.sv
// Routes the ioctl download stream to game ROM / SYSMODE / DIP registers and
// holds the System 1 game core in reset until a complete ROM image has settled.
module sys1_load_sequencer #(
  parameter logic [23:0] ROM_SIZE      = 24'h060000,
  parameter logic [15:0] SETTLE_CYCLES = 16'd4096
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  sys1_load_sequencer_if.slave        ioctl,
  input  logic                        user_reset,
  output logic                        rom_we,
  output logic [24:0]                 rom_addr,
  output logic [7:0]                  rom_data,
  output logic [7:0]                  sysmode,
  output logic [63:0]                 dsw,
  output logic                        core_reset,
  output logic                        rom_valid,
  output logic                        short_load
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StSettle = 2'd2;
  localparam logic [1:0] StRun    = 2'd3;

  localparam logic [24:0] RomLimit   = {1'b0, ROM_SIZE};
  localparam logic [15:0] SettleLast = SETTLE_CYCLES - 16'd1;

  logic [1:0]  state_q, state_d;
  logic        dl_q, dl_d;
  logic        act_q, act_d;
  logic [7:0]  idx_q, idx_d;
  logic [24:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] settle_q, settle_d;
  logic        rom_we_q, rom_we_d;
  logic [24:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [7:0]  sysmode_q, sysmode_d;
  logic [63:0] dsw_q, dsw_d;
  logic        core_reset_q, core_reset_d;
  logic        rom_valid_q, rom_valid_d;
  logic        short_load_q, short_load_d;

  logic dl_rise, dl_fall, load_idx, wr_ok, rom_acc;

  always_comb begin
    dl_rise  = ioctl.ioctl_download & ~dl_q;
    dl_fall  = ~ioctl.ioctl_download & dl_q & act_q;
    load_idx = (ioctl.ioctl_index == 8'd0) || (ioctl.ioctl_index == 8'd1);
    wr_ok    = ioctl.ioctl_wr & act_q;
    rom_acc  = wr_ok && (idx_q == 8'd0) && (state_q == StLoad) &&
               (ioctl.ioctl_addr < RomLimit);

    state_d      = state_q;
    dl_d         = ioctl.ioctl_download;
    act_d        = ioctl.ioctl_download & (act_q | dl_rise);
    idx_d        = dl_rise ? ioctl.ioctl_index : idx_q;
    byte_cnt_d   = byte_cnt_q;
    settle_d     = settle_q;
    rom_we_d     = rom_acc;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    sysmode_d    = sysmode_q;
    dsw_d        = dsw_q;
    rom_valid_d  = rom_valid_q;
    short_load_d = short_load_q;

    if (rom_acc) begin
      rom_addr_d = ioctl.ioctl_addr;
      rom_data_d = ioctl.ioctl_dout;
      if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + 25'd1;
    end
    if (wr_ok && (idx_q == 8'd1) && (ioctl.ioctl_addr == 25'd0)) begin
      sysmode_d = ioctl.ioctl_dout;
    end
    if (wr_ok && (idx_q == 8'd254) && (ioctl.ioctl_addr[24:3] == 22'd0)) begin
      dsw_d[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] = ioctl.ioctl_dout;
    end

    unique case (state_q)
      StIdle: begin
        if (dl_rise && load_idx) state_d = StLoad;
      end
      StLoad: begin
        if (dl_fall) begin
          settle_d = '0;
          if (idx_q == 8'd0) begin
            // byte_cnt_d so a write landing on the falling-edge cycle still counts
            if (byte_cnt_d >= RomLimit) begin
              rom_valid_d = 1'b1;
              state_d     = StSettle;
            end else begin
              short_load_d = 1'b1;
              state_d      = StIdle;
            end
          end else begin
            state_d = rom_valid_q ? StSettle : StIdle;
          end
        end
      end
      StSettle: begin
        if (dl_rise && load_idx) begin
          state_d = StLoad;
        end else if (user_reset) begin
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          state_d = StRun;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      StRun: begin
        if (dl_rise && load_idx) begin
          state_d = StLoad;
        end else if (user_reset) begin
          state_d  = StSettle;
          settle_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (dl_rise && load_idx && (state_q != StLoad) && (ioctl.ioctl_index == 8'd0)) begin
      rom_valid_d  = 1'b0;
      short_load_d = 1'b0;
      byte_cnt_d   = '0;
    end

    core_reset_d = (state_d != StRun);
  end

  // dl_q resets high so a download still in flight when reset drops is not seen as a new
  // rising edge; its remaining bytes are ignored until the next genuine edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      dl_q         <= 1'b1;
      act_q        <= 1'b0;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      settle_q     <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      sysmode_q    <= '0;
      dsw_q        <= '0;
      core_reset_q <= 1'b1;
      rom_valid_q  <= 1'b0;
      short_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      act_q        <= act_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      settle_q     <= settle_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      sysmode_q    <= sysmode_d;
      dsw_q        <= dsw_d;
      core_reset_q <= core_reset_d;
      rom_valid_q  <= rom_valid_d;
      short_load_q <= short_load_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign sysmode    = sysmode_q;
  assign dsw        = dsw_q;
  assign core_reset = core_reset_q;
  assign rom_valid  = rom_valid_q;
  assign short_load = short_load_q;

endmodule

// File: tb/tb_sys1_load_sequencer.sv
// Directed download scenarios with random payloads for sys1_load_sequencer, checked
// against a download-level model (expected writes, captured bytes, settle delay).
module tb_sys1_load_sequencer;
  localparam logic [23:0] RomSize      = 24'h000040;
  localparam logic [15:0] SettleCycles = 16'd20;
  localparam int          RomN         = 64;
  localparam int          SettleN      = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        user_reset = 1'b0;
  logic        rom_we;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sysmode;
  logic [63:0] dsw;
  logic        core_reset;
  logic        rom_valid;
  logic        short_load;

  sys1_load_sequencer_if bus ();

  sys1_load_sequencer #(
    .ROM_SIZE      (RomSize),
    .SETTLE_CYCLES (SettleCycles)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ioctl      (bus),
    .user_reset (user_reset),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sysmode    (sysmode),
    .dsw        (dsw),
    .core_reset (core_reset),
    .rom_valid  (rom_valid),
    .short_load (short_load)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;

  // Reference model state, at the level of downloads and captured bytes.
  bit         m_active;
  bit         m_loading;
  logic [7:0] m_idx;
  int         m_cnt;
  int         we_seen;
  bit         exp_rv;
  bit         exp_sl;
  logic [7:0] exp_sysmode;
  logic [7:0] exp_dsw_b [8];

  function automatic logic [63:0] exp_dsw();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = exp_dsw_b[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset();
    m_active = 0; m_loading = 0; exp_rv = 0; exp_sl = 0; exp_sysmode = 8'h00;
    for (int i = 0; i < 8; i++) exp_dsw_b[i] = 8'h00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_we"}, 64'(rom_we), 64'd0);
    chk({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_rom_data"}, 64'(rom_data), 64'd0);
    chk({tag, "_sysmode"}, 64'(sysmode), 64'd0);
    chk({tag, "_dsw"}, dsw, 64'd0);
    chk({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_rom_valid"}, 64'(rom_valid), 64'd0);
    chk({tag, "_short_load"}, 64'(short_load), 64'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
    m_active = 1;
    m_idx    = idx;
    if (idx == 8'd0 || idx == 8'd1) m_loading = 1;
    if (idx == 8'd0) begin
      m_cnt = 0; exp_rv = 0; exp_sl = 0;
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    bit exp_we;
    exp_we = m_loading && m_active && (m_idx == 8'd0) && (a < 25'(RomN));
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    chk("rom_we", 64'(rom_we), 64'(exp_we));
    if (exp_we) begin
      chk("rom_addr", 64'(rom_addr), 64'(a));
      chk("rom_data", 64'(rom_data), 64'(d));
      m_cnt++;
    end
    if (rom_we === 1'b1) we_seen++;
    if (m_active && m_idx == 8'd1 && a == 25'd0) exp_sysmode = d;
    if (m_active && m_idx == 8'd254 && a < 25'd8) exp_dsw_b[a[2:0]] = d;
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
    if (m_loading && m_active && m_idx == 8'd0) begin
      if (m_cnt >= RomN) exp_rv = 1;
      else exp_sl = 1;
    end
    m_loading = 0;
    m_active  = 0;
    chk("rom_valid_end", 64'(rom_valid), 64'(exp_rv));
    chk("short_load_end", 64'(short_load), 64'(exp_sl));
  endtask

  task automatic load_rom(input int n);
    start_dl(8'd0);
    chk("core_reset_load", 64'(core_reset), 64'd1);
    for (int i = 0; i < n; i++) wr(25'(i), 8'($urandom));
    end_dl();
  endtask

  // Count cycles until core_reset drops; bounded so a stuck reset still reaches the summary.
  task automatic wait_run(input string tag, input int exp_n);
    int n;
    n = 0;
    while (core_reset === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    model_reset();
    m_idx = 8'd0; m_cnt = 0; we_seen = 0;
    tick();
    tick();
    chk_reset_vals("por");
    reset = 1'b0;
    tick();

    // Short image: flagged, never leaves reset.
    load_rom(RomN - 1);
    repeat (SettleN + 5) tick();
    chk("core_reset_short", 64'(core_reset), 64'd1);

    // Full image straight after a short one.
    we_seen = 0;
    load_rom(RomN);
    chk("we_count_full", 64'(we_seen), 64'(RomN));
    wait_run("settle_after_load", SettleN);

    // User reset held for 10 cycles in RUN.
    user_reset = 1'b1;
    tick();
    chk("core_reset_user", 64'(core_reset), 64'd1);
    repeat (9) tick();
    user_reset = 1'b0;
    wait_run("settle_after_user", SettleN);

    // Live DIP bytes in RUN, plus one out-of-range address.
    start_dl(8'd254);
    for (int i = 0; i < 8; i++) begin
      wr(25'(i), 8'hA0 + 8'(i));
      chk("core_reset_dip", 64'(core_reset), 64'd0);
    end
    wr(25'd8 + 25'($urandom_range(0, 200)), 8'($urandom));
    end_dl();
    chk("dsw_fixed", dsw, 64'hA7A6A5A4A3A2A1A0);
    chk("dsw_model", dsw, exp_dsw());
    chk("core_reset_after_dip", 64'(core_reset), 64'd0);

    // SYSMODE download restarts the settle sequence.
    start_dl(8'd1);
    chk("core_reset_sysmode", 64'(core_reset), 64'd1);
    wr(25'd0, 8'h35);
    wr(25'd1 + 25'($urandom_range(0, 100)), 8'($urandom));
    end_dl();
    chk("sysmode", 64'(sysmode), 64'(exp_sysmode));
    chk("sysmode_fixed", 64'(sysmode), 64'h35);
    wait_run("settle_after_sysmode", SettleN);

    // Oversized image, rising edge coincident with user_reset, user_reset held into LOAD.
    we_seen = 0;
    user_reset = 1'b1;
    start_dl(8'd0);
    chk("core_reset_load_wins", 64'(core_reset), 64'd1);
    for (int i = 0; i < RomN + 16; i++) begin
      if (i == 3) user_reset = 1'b0;
      wr(25'(i), 8'($urandom));
    end
    end_dl();
    chk("we_count_over", 64'(we_seen), 64'(RomN));
    wait_run("settle_after_over", SettleN);

    // Async reset in the middle of an index-0 download.
    start_dl(8'd0);
    for (int i = 0; i < 5; i++) wr(25'(i), 8'($urandom));
    reset = 1'b1;
    #2;
    model_reset();
    chk_reset_vals("mid_reset");
    tick();
    reset = 1'b0;
    for (int i = 5; i < 10; i++) wr(25'(i), 8'($urandom));
    end_dl();
    repeat (SettleN + 5) tick();
    chk("core_reset_after_abort", 64'(core_reset), 64'd1);

    // A fresh download after the abort loads normally.
    we_seen = 0;
    load_rom(RomN);
    chk("we_count_reload", 64'(we_seen), 64'(RomN));
    wait_run("settle_after_reload", SettleN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
